spi_tx_master: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) master transmit engine for the spi_master block.
- Accepts one byte per transaction over a valid/ready handshake, asserts chip select, and generates SCLK from the system clock.
- Shifts the byte out on MOSI, MSB first.
- Emits a one-cycle sample strobe per SCLK rising edge. This strobe drives the MISO shift receiver's sample input directly, so a full-duplex byte is exchanged per transaction.

---
 rtl/spi_tx_master.sv | 82 ++++++++
 tb/tb_spi_tx_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI mode-0 byte transmitter with MISO sample strobe on each SCLK rising edge
module spi_tx_master #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_clk_spi_sample,
    output logic       o_done
);
    localparam int CW = $clog2(HALF_PERIOD) + 1;
    typedef enum logic [1:0] {IDLE, SETUP, SCLK_HIGH, SCLK_LOW} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_cnt;
    logic [6:0] sr;
    logic phase_end;
    assign phase_end = cnt == CW'(HALF_PERIOD - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            sr <= '0;
            o_tx_ready <= 1'b1;
            o_sclk <= 1'b0;
            o_mosi <= 1'b0;
            o_cs_n <= 1'b1;
            o_clk_spi_sample <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_clk_spi_sample <= 1'b0;
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_tx_valid && o_tx_ready) begin
                    sr <= i_tx_byte[6:0];
                    o_mosi <= i_tx_byte[7];
                    o_cs_n <= 1'b0;
                    o_tx_ready <= 1'b0;
                    cnt <= '0;
                    bit_cnt <= '0;
                    state <= SETUP;
                end
                SETUP: if (phase_end) begin
                    cnt <= '0;
                    o_sclk <= 1'b1;
                    o_clk_spi_sample <= 1'b1;
                    state <= SCLK_HIGH;
                end else cnt <= cnt + 1'b1;
                SCLK_HIGH: if (phase_end) begin
                    cnt <= '0;
                    o_sclk <= 1'b0;
                    state <= SCLK_LOW;
                    if (bit_cnt != 3'd7) begin
                        o_mosi <= sr[6];
                        sr <= {sr[5:0], 1'b0};
                    end
                end else cnt <= cnt + 1'b1;
                SCLK_LOW: if (phase_end) begin
                    cnt <= '0;
                    if (bit_cnt == 3'd7) begin
                        o_cs_n <= 1'b1;
                        o_done <= 1'b1;
                        o_tx_ready <= 1'b1;
                        o_mosi <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        o_sclk <= 1'b1;
                        o_clk_spi_sample <= 1'b1;
                        state <= SCLK_HIGH;
                    end
                end else cnt <= cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master: directed checks of the SPI transmitter at HALF_PERIOD 4 and 1
module tb_spi_tx_master;
    logic clk = 1'b0;
    logic rst;
    logic mon_clr;
    logic [1:0] valid;
    logic [7:0] tx_byte [2];
    logic [1:0] ready, sclk, mosi, cs_n, smp, done;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    for (genvar k = 0; k < 2; k++) begin : g
        localparam int HP = k == 0 ? 4 : 1;
        int cyc, low_run, high_run, last_low, last_high, fall, last_s, tsamp;
        int nsamp, ndone, done_bad, bad_gap, first_dly;
        logic pcs = 1'b1;
        logic [15:0] bits;
        logic [7:0] rx, rx_done;
        spi_tx_master #(.HALF_PERIOD(HP)) dut (
            .clk(clk),
            .reset(rst),
            .i_tx_byte(tx_byte[k]),
            .i_tx_valid(valid[k]),
            .o_tx_ready(ready[k]),
            .o_sclk(sclk[k]),
            .o_mosi(mosi[k]),
            .o_cs_n(cs_n[k]),
            .o_clk_spi_sample(smp[k]),
            .o_done(done[k])
        );
        always @(negedge clk) begin
            cyc++;
            if (cs_n[k] && !pcs) begin
                last_low = low_run;
                low_run = 0;
            end
            if (!cs_n[k] && pcs) begin
                last_high = high_run;
                high_run = 0;
                fall = cyc;
                tsamp = 0;
            end
            if (cs_n[k]) high_run++;
            else low_run++;
            if (mon_clr) begin
                nsamp = 0;
                ndone = 0;
                done_bad = 0;
                bad_gap = 0;
                first_dly = -1;
                bits = '0;
                rx = '0;
                rx_done = '0;
            end else begin
                if (smp[k]) begin
                    if (tsamp == 0) first_dly = cyc - fall;
                    else if (cyc - last_s != 2 * HP) bad_gap++;
                    last_s = cyc;
                    tsamp++;
                    nsamp++;
                    rx = {rx[6:0], mosi[k]};
                    bits = {bits[14:0], mosi[k]};
                end
                if (done[k]) begin
                    ndone++;
                    rx_done = rx;
                    if (!(cs_n[k] && !pcs)) done_bad++;
                end
            end
            pcs = cs_n[k];
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        @(posedge clk); #2;
        mon_clr = 1'b1;
        @(posedge clk); #2;
        mon_clr = 1'b0;
    endtask
    task automatic send(input int k, input logic [7:0] b);
        @(posedge clk); #2;
        valid[k] = 1'b1;
        tx_byte[k] = b;
        @(posedge clk); #2;
        valid[k] = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        mon_clr = 1'b0;
        valid = '0;
        tx_byte[0] = '0;
        tx_byte[1] = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(ready), 32'h3);
        check("rst_sclk", 32'(sclk), 32'h0);
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_mosi", 32'(mosi), 32'h0);
        check("rst_smp", 32'(smp), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        clr();
        send(0, 8'hA5);
        repeat (80) @(posedge clk);
        check("a5_bits", 32'(g[0].bits[7:0]), 32'hA5);
        check("a5_nsamp", g[0].nsamp, 8);
        check("a5_cs_low", g[0].last_low, 68);
        check("a5_first_dly", g[0].first_dly, 4);
        check("a5_gap", g[0].bad_gap, 0);
        check("a5_ndone", g[0].ndone, 1);
        check("a5_done_at_rise", g[0].done_bad, 0);
        clr();
        send(0, 8'h3C);
        repeat (80) @(posedge clk);
        check("loop_rx", 32'(g[0].rx_done), 32'h3C);
        clr();
        @(posedge clk); #2;
        valid[0] = 1'b1;
        tx_byte[0] = 8'h3C;
        @(posedge clk); #2;
        tx_byte[0] = 8'hC3;
        for (int i = 0; i < 100 && g[0].ndone < 1; i++) @(negedge clk);
        check("b2b_first_done", g[0].ndone, 1);
        @(posedge clk); #2;
        valid[0] = 1'b0;
        repeat (80) @(posedge clk);
        check("b2b_bits", 32'(g[0].bits), 32'h3CC3);
        check("b2b_nsamp", g[0].nsamp, 16);
        check("b2b_ndone", g[0].ndone, 2);
        check("b2b_cs_high", g[0].last_high, 1);
        check("b2b_gap", g[0].bad_gap, 0);
        clr();
        send(0, 8'h00);
        repeat (20) @(posedge clk);
        #2;
        valid[0] = 1'b1;
        tx_byte[0] = 8'hFF;
        @(posedge clk); #2;
        valid[0] = 1'b0;
        repeat (80) @(posedge clk);
        check("busy_bits", 32'(g[0].bits), 32'h0);
        check("busy_nsamp", g[0].nsamp, 8);
        check("busy_ndone", g[0].ndone, 1);
        check("busy_idle_cs_n", 32'(cs_n[0]), 32'h1);
        clr();
        send(0, 8'hFF);
        for (int i = 0; i < 60 && g[0].nsamp < 3; i++) @(negedge clk);
        check("rst_mid_wait", g[0].nsamp, 3);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_cs_n", 32'(cs_n[0]), 32'h1);
        check("rst_mid_sclk", 32'(sclk[0]), 32'h0);
        check("rst_mid_mosi", 32'(mosi[0]), 32'h0);
        check("rst_mid_ready", 32'(ready[0]), 32'h1);
        check("rst_mid_smp", 32'(smp[0]), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("rst_mid_no_done", g[0].ndone, 0);
        clr();
        send(0, 8'h81);
        repeat (80) @(posedge clk);
        check("post_rst_bits", 32'(g[0].bits[7:0]), 32'h81);
        check("post_rst_nsamp", g[0].nsamp, 8);
        check("post_rst_ndone", g[0].ndone, 1);
        check("post_rst_cs_low", g[0].last_low, 68);
        clr();
        send(1, 8'h96);
        repeat (30) @(posedge clk);
        check("hp1_bits", 32'(g[1].bits[7:0]), 32'h96);
        check("hp1_nsamp", g[1].nsamp, 8);
        check("hp1_cs_low", g[1].last_low, 17);
        check("hp1_first_dly", g[1].first_dly, 1);
        check("hp1_gap", g[1].bad_gap, 0);
        check("hp1_ndone", g[1].ndone, 1);
        check("hp1_done_at_rise", g[1].done_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
